// File: rtl/min_press_combination_search.sv
// rtl/min_press_combination_search.sv - sequential minimum-press button combination search
// Optional feature: define MATCH_COUNT_EN to add the match_count output and counter.
module min_press_combination_search #(
   parameter  int MAX_BUTTON_COUNT = 13,
   parameter  int LIGHT_COUNT      = 10,
   localparam int CNT_W            = $clog2(MAX_BUTTON_COUNT + 1)
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic [CNT_W-1:0]                      button_count,
   input  logic [LIGHT_COUNT-1:0]                target,
   input  logic [MAX_BUTTON_COUNT*LIGHT_COUNT-1:0] flattened_buttons,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  found,
   output logic [CNT_W-1:0]                      min_presses,
`ifdef MATCH_COUNT_EN
   output logic [MAX_BUTTON_COUNT:0]             match_count,
`endif
   output logic [MAX_BUTTON_COUNT-1:0]           best_combination
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                                  state_q, state_d;
   logic [MAX_BUTTON_COUNT:0]               cnt_q, cnt_d;
   logic [CNT_W-1:0]                        n_q, n_d;
   logic [LIGHT_COUNT-1:0]                  target_q, target_d;
   logic [MAX_BUTTON_COUNT*LIGHT_COUNT-1:0] buttons_q, buttons_d;
   logic                                    busy_q, busy_d;
   logic                                    done_q, done_d;
   logic                                    found_q, found_d;
   logic [CNT_W-1:0]                        min_q, min_d;
   logic [MAX_BUTTON_COUNT-1:0]             best_q, best_d;
   logic [MAX_BUTTON_COUNT:0]               match_q, match_d;

   logic [LIGHT_COUNT-1:0]                  xor_r;
   logic [CNT_W-1:0]                        pop_c;
   logic [CNT_W-1:0]                        n_clamped;
   logic [MAX_BUTTON_COUNT:0]               last_c;
   logic                                    is_match;

   localparam logic [MAX_BUTTON_COUNT:0] ONE_W = (MAX_BUTTON_COUNT + 1)'(1);

   // XOR of the selected buttons' masks and press count for the current combination
   always_comb begin
      xor_r = '0;
      pop_c = '0;
      for (int j = 0; j < MAX_BUTTON_COUNT; j++) begin
         if (cnt_q[j]) begin
            xor_r = xor_r ^ buttons_q[j*LIGHT_COUNT +: LIGHT_COUNT];
            pop_c = pop_c + CNT_W'(1);
         end
      end
      is_match  = (xor_r == target_q);
      // last_c = 2^n - 1; the extra counter bit keeps 2^MAX representable
      last_c    = (ONE_W << n_q) - ONE_W;
      n_clamped = (button_count > CNT_W'(MAX_BUTTON_COUNT)) ? CNT_W'(MAX_BUTTON_COUNT) : button_count;
   end

   // Next-state logic: accept in IDLE, walk combinations in SEARCH, one-cycle DONE
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      n_d       = n_q;
      target_d  = target_q;
      buttons_d = buttons_q;
      found_d   = found_q;
      min_d     = min_q;
      best_d    = best_q;
      match_d   = match_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SEARCH;
               cnt_d     = '0;
               n_d       = n_clamped;
               target_d  = target;
               buttons_d = flattened_buttons;
               found_d   = 1'b0;
               min_d     = '0;
               best_d    = '0;
               match_d   = '0;
            end
         end
         S_SEARCH: begin
            if (is_match) begin
               match_d = match_q + ONE_W;
               // strict less-than keeps the earliest (lowest) combination on ties
               if (!found_q || (pop_c < min_q)) begin
                  found_d = 1'b1;
                  min_d   = pop_c;
                  best_d  = cnt_q[MAX_BUTTON_COUNT-1:0];
               end
            end
            cnt_d = cnt_q + ONE_W;
            if (cnt_q == last_c) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and result registers; reset aborts any search in progress
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         n_q       <= '0;
         target_q  <= '0;
         buttons_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         found_q   <= 1'b0;
         min_q     <= '0;
         best_q    <= '0;
         match_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         n_q       <= n_d;
         target_q  <= target_d;
         buttons_q <= buttons_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         found_q   <= found_d;
         min_q     <= min_d;
         best_q    <= best_d;
         match_q   <= match_d;
      end
   end

   assign busy             = busy_q;
   assign done             = done_q;
   assign found            = found_q;
   assign min_presses      = min_q;
   assign best_combination = best_q;
`ifdef MATCH_COUNT_EN
   assign match_count      = match_q;
`else
   logic unused_match;
   assign unused_match = ^match_q;
`endif

endmodule

// File: tb/tb_min_press_combination_search.sv
// tb/tb_min_press_combination_search.sv - randomized self-checking bench with reference model
module tb_min_press_combination_search;

   localparam int MB = 13;
   localparam int LC = 10;
   localparam int CW = $clog2(MB + 1);

   logic             clk = 1'b0;
   logic             rst_n;
   logic             start;
   logic [CW-1:0]    button_count;
   logic [LC-1:0]    target;
   logic [MB*LC-1:0] flattened_buttons;
   logic             busy;
   logic             done;
   logic             found;
   logic [CW-1:0]    min_presses;
   logic [MB-1:0]    best_combination;
`ifdef MATCH_COUNT_EN
   logic [MB:0]      match_count;
`endif

   min_press_combination_search #(
      .MAX_BUTTON_COUNT(MB),
      .LIGHT_COUNT(LC)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .button_count(button_count),
      .target(target),
      .flattened_buttons(flattened_buttons),
      .busy(busy),
      .done(done),
      .found(found),
      .min_presses(min_presses),
`ifdef MATCH_COUNT_EN
      .match_count(match_count),
`endif
      .best_combination(best_combination)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int m_n;
   int m_tgt;
   int m_btn[MB];
   int exp_found, exp_min, exp_best, exp_cnt, exp_cycles;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Brute-force enumeration of every press subset of the first n buttons
   task automatic model_run();
      int n;
      int r;
      exp_found = 0; exp_min = 0; exp_best = 0; exp_cnt = 0;
      n = (m_n > MB) ? MB : m_n;
      for (int c = 0; c < (1 << n); c++) begin
         r = 0;
         for (int j = 0; j < n; j++)
            if (((c >> j) & 1) == 1) r = r ^ m_btn[j];
         if (r == m_tgt) begin
            exp_cnt++;
            if (exp_found == 0 || $countones(c) < exp_min) begin
               exp_found = 1;
               exp_min   = $countones(c);
               exp_best  = c;
            end
         end
      end
      exp_cycles = (1 << n) + 1;
   endtask

   task automatic apply_inputs();
      button_count = CW'(m_n);
      target       = LC'(m_tgt);
      for (int j = 0; j < MB; j++)
         flattened_buttons[j*LC +: LC] = LC'(m_btn[j]);
   endtask

   // Entered and left at 1 time unit after a rising edge
   task automatic run(input string tag, input bit meddle);
      int cycles;
      model_run();
      apply_inputs();
      start = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
      cycles = 1;
      while (!done && cycles < 10000) begin
         if (meddle && cycles == 3) begin
            start             = 1'b1;
            target            = LC'($urandom);
            button_count      = CW'($urandom);
            flattened_buttons = {$urandom, $urandom, $urandom, $urandom, $urandom};
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0;
      chk({tag, "_done_seen"}, done, 1);
      chk({tag, "_latency"}, cycles, exp_cycles);
      chk({tag, "_busy_at_done"}, busy, 1);
      chk({tag, "_found"}, found, exp_found);
      chk({tag, "_min"}, min_presses, exp_min);
      chk({tag, "_best"}, best_combination, exp_best);
`ifdef MATCH_COUNT_EN
      chk({tag, "_match_count"}, match_count, exp_cnt);
`endif
      if (meddle) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({tag, "_done_pulse"}, done, 0);
      chk({tag, "_busy_low"}, busy, 0);
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_hold_found"}, found, exp_found);
      chk({tag, "_hold_best"}, best_combination, exp_best);
   endtask

   task automatic rand_machine(input int n);
      int sel;
      m_n = n;
      for (int j = 0; j < MB; j++) m_btn[j] = $urandom_range(0, (1 << LC) - 1);
      if ($urandom_range(0, 3) != 0 && n > 0) begin
         sel   = $urandom_range(0, (1 << n) - 1);
         m_tgt = 0;
         for (int j = 0; j < n; j++)
            if (((sel >> j) & 1) == 1) m_tgt = m_tgt ^ m_btn[j];
      end else begin
         m_tgt = $urandom_range(0, (1 << LC) - 1);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      button_count = '0;
      target = '0;
      flattened_buttons = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_found", found, 0);
      chk("reset_min", min_presses, 0);
      chk("reset_best", best_combination, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // reset mid-search with an early match so clearing is observable
      rand_machine(8);
      m_tgt = 0;
      apply_inputs();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(posedge clk);
      #3;
      chk("pre_reset_found", found, 1);
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy, 0);
      chk("midrst_found", found, 0);
      chk("midrst_min", min_presses, 0);
      chk("midrst_best", best_combination, 0);
`ifdef MATCH_COUNT_EN
      chk("midrst_match", match_count, 0);
`endif
      @(posedge clk); #1;
      chk("midrst_no_done", done, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      run("after_reset", 1'b0);

      // sample machine
      m_n = 6;
      m_tgt = 6;
      for (int j = 0; j < MB; j++) m_btn[j] = 0;
      m_btn[0] = 8; m_btn[1] = 10; m_btn[2] = 4;
      m_btn[3] = 12; m_btn[4] = 5; m_btn[5] = 3;
      run("sample", 1'b0);
      chk("sample_best_const", best_combination, 10);

      // no solution
      for (int j = 0; j < MB; j++) m_btn[j] = 0;
      m_n = 1; m_btn[0] = 1; m_tgt = 2;
      run("nosol", 1'b0);

      // n = 0
      m_n = 0; m_tgt = 0;
      run("n0_t0", 1'b0);
      m_n = 0; m_tgt = 1;
      run("n0_t1", 1'b0);

      // handshake: start pulses in SEARCH and DONE, inputs change mid-search
      rand_machine(5);
      run("handshake", 1'b1);

      // clamp of out-of-range button_count
      rand_machine(6);
      m_n = 14;
      run("clamp", 1'b0);

      // full width, all-zero buttons
      for (int j = 0; j < MB; j++) m_btn[j] = 0;
      m_n = MB; m_tgt = 0;
      run("nmax", 1'b0);

      for (int k = 0; k < 12; k++) begin
         rand_machine($urandom_range(0, 8));
         run("rand", 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
